// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I$/D$ memory-side arbiter.
//   grant_state_t : arbiter FSM state; encoding doubles as the grant_o debug value
//   ARB_STARVE_W  : width of the I$ starvation counter
//   LAST_I/LAST_D : encoding of the last-grant flop
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } grant_state_t;

  localparam int   ARB_STARVE_W = 4;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational next-grant selector used while the arbiter is idle.
//   i_req, d_req : qualified requests from I$ and D$
//   last_grant   : side that owned the previous transaction (LAST_I / LAST_D)
//   starve_cnt   : consecutive D$ grants taken while I$ was waiting
//   next_grant   : IDLE, GRANT_I or GRANT_D
module arb_pick
  import cache_arb_pkg::*;
#(
  parameter int ROUND_ROBIN  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_req,
  input  logic                    d_req,
  input  logic                    last_grant,
  input  logic [ARB_STARVE_W-1:0] starve_cnt,
  output grant_state_t            next_grant
);

  localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(STARVE_LIMIT);

  always_comb begin
    next_grant = IDLE;
    if (i_req && d_req) begin
      if (ROUND_ROBIN != 0) begin
        next_grant = (last_grant == LAST_I) ? GRANT_D : GRANT_I;
      end else begin
        // D$ wins unless I$ has already waited out its full allowance
        next_grant = (starve_cnt == LIMIT) ? GRANT_I : GRANT_D;
      end
    end else if (d_req) begin
      next_grant = GRANT_D;
    end else if (i_req) begin
      next_grant = GRANT_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Merges the I$ and D$ memory-side generic buses onto one memory bus.
// One transaction is owned at a time; the grant is held until memory drops
// m_busy, then the arbiter spends one idle cycle before the next grant.
// Ports:
//   CLK, nRST                : clock, async active-low reset
//   i_* (addr/ren/abort)     : I$ read-only request side, i_rdata/i_busy back
//   d_* (addr/wdata/ren/wen/byte_en) : D$ request side, d_rdata/d_busy back
//   m_* (addr/wdata/ren/wen/byte_en) : memory request, m_rdata/m_busy back
//   grant_o                  : debug, 00 idle / 01 I$ / 10 D$
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ROUND_ROBIN  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  input  logic        i_abort,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_ren,
  output logic        m_wen,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  output logic [1:0]  grant_o
);

  localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(STARVE_LIMIT);

  grant_state_t            state_q, state_d, pick;
  logic                    last_grant_q, last_grant_d;
  logic [ARB_STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    i_req, d_req;

  // Abort only masks a fetch that has not been granted yet
  assign i_req = i_ren & ~i_abort;
  assign d_req = d_ren | d_wen;

  arb_pick #(
    .ROUND_ROBIN  (ROUND_ROBIN),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .starve_cnt (starve_cnt_q),
    .next_grant (pick)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    m_addr       = '0;
    m_wdata      = '0;
    m_ren        = 1'b0;
    m_wen        = 1'b0;
    m_byte_en    = '0;
    i_rdata      = '0;
    d_rdata      = '0;
    i_busy       = 1'b1;
    d_busy       = 1'b1;

    case (state_q)
      IDLE: state_d = pick;

      GRANT_D: begin
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        m_ren     = d_ren;
        m_wen     = d_wen;
        m_byte_en = d_byte_en;
        d_rdata   = m_rdata;
        d_busy    = m_busy;
        if (!d_req) begin
          // requester dropped early: release without touching fairness state
          state_d = IDLE;
        end else if (!m_busy) begin
          state_d      = IDLE;
          last_grant_d = LAST_D;
          if (i_req)
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
          else
            starve_cnt_d = '0;
        end
      end

      GRANT_I: begin
        m_addr    = i_addr;
        m_ren     = i_ren;   // follows a dropped request; abort is ignored here
        m_byte_en = 4'hF;
        i_rdata   = m_rdata;
        i_busy    = m_busy;
        if (!i_ren) begin
          state_d = IDLE;
        end else if (!m_busy) begin
          state_d      = IDLE;
          last_grant_d = LAST_I;
          starve_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_o = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_I;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
